// File: rtl/bus_memory_responder_if.sv
// Bus-side signals of the memory responder: request handshake, snoop
// intervention and RM response channel.
interface bus_memory_responder_if #(
    parameter int TAG_W  = 2,
    parameter int DATA_W = 4
);
    localparam int WORD_W = 2 + TAG_W + DATA_W;

    logic [WORD_W-1:0] bus_req;
    logic              bus_req_valid;
    logic              bus_req_ready;
    logic              snoop_hit;
    logic [DATA_W-1:0] snoop_value;
    logic              resp_valid;
    logic [WORD_W-1:0] resp_data;
    logic              resp_ready;

    modport slave (
        input  bus_req, bus_req_valid, snoop_hit, snoop_value, resp_ready,
        output bus_req_ready, resp_valid, resp_data
    );

    modport master (
        output bus_req, bus_req_valid, snoop_hit, snoop_value, resp_ready,
        input  bus_req_ready, resp_valid, resp_data
    );
endinterface

// File: rtl/bus_memory_responder.sv
// Main-memory end of the snooping bus: services RM with modelled latency,
// commits WB, and absorbs a cache's modified copy when it intervenes on RM.
module bus_memory_responder #(
    parameter int TAGS    = 4,
    parameter int DATA_W  = 4,
    parameter int LATENCY = 2,
    parameter int RM      = 1,
    parameter int RH      = 2,
    parameter int WB      = 3,
    localparam int TAG_W  = $clog2(TAGS)
) (
    input  logic                  clock,
    input  logic                  reset,
    bus_memory_responder_if.slave bus,
    input  logic [TAG_W-1:0]      dbg_tag,
    output logic [DATA_W-1:0]     dbg_value
);
    localparam int WORD_W = 2 + TAG_W + DATA_W;
    localparam int CNT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_READ_WAIT = 2'd1;
    localparam logic [1:0] S_RESPOND   = 2'd2;
    localparam logic [1:0] S_WRITE     = 2'd3;

    localparam logic [1:0] MSG_RM = 2'(RM);
    localparam logic [1:0] MSG_RH = 2'(RH);
    localparam logic [1:0] MSG_WB = 2'(WB);

    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [TAG_W-1:0]  tag_q, tag_d;
    logic [DATA_W-1:0] val_q, val_d;
    logic              resp_valid_q, resp_valid_d;
    logic [WORD_W-1:0] resp_data_q, resp_data_d;
    logic [DATA_W-1:0] mem_q [TAGS];
    logic [DATA_W-1:0] mem_d [TAGS];

    logic [1:0]        req_msg;
    logic [TAG_W-1:0]  req_tag;
    logic [DATA_W-1:0] req_val;

    assign req_msg = bus.bus_req[WORD_W-1 -: 2];
    assign req_tag = bus.bus_req[DATA_W +: TAG_W];
    assign req_val = bus.bus_req[DATA_W-1:0];

    assign bus.bus_req_ready = (state_q == S_IDLE);
    assign bus.resp_valid    = resp_valid_q;
    assign bus.resp_data     = resp_data_q;
    assign dbg_value         = mem_q[dbg_tag];

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        tag_d        = tag_q;
        val_d        = val_q;
        resp_valid_d = resp_valid_q;
        resp_data_d  = resp_data_q;
        mem_d        = mem_q;

        case (state_q)
            S_IDLE: begin
                if (bus.bus_req_valid) begin
                    case (req_msg)
                        MSG_RM: begin
                            tag_d   = req_tag;
                            cnt_d   = CNT_W'(LATENCY - 1);
                            state_d = S_READ_WAIT;
                        end
                        MSG_WB: begin
                            tag_d   = req_tag;
                            val_d   = req_val;
                            state_d = S_WRITE;
                        end
                        MSG_RH, 2'd0: ;
                        default: ;
                    endcase
                end
            end
            S_READ_WAIT: begin
                // Intervention takes priority even on the cycle the response would issue
                if (bus.snoop_hit) begin
                    mem_d[tag_q] = bus.snoop_value;
                    state_d      = S_IDLE;
                end else if (cnt_q == '0) begin
                    resp_data_d  = {MSG_RM, tag_q, mem_q[tag_q]};
                    resp_valid_d = 1'b1;
                    state_d      = S_RESPOND;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_RESPOND: begin
                if (bus.resp_ready) begin
                    resp_valid_d = 1'b0;
                    state_d      = S_IDLE;
                end
            end
            S_WRITE: begin
                mem_d[tag_q] = val_q;
                state_d      = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            tag_q        <= '0;
            val_q        <= '0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
            for (int unsigned i = 0; i < TAGS; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            tag_q        <= tag_d;
            val_q        <= val_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            mem_q        <= mem_d;
        end
    end
endmodule

// File: tb/tb_bus_memory_responder.sv
// Directed bench for bus_memory_responder; RM responses are checked by a
// queue-driven monitor independent of the stimulus thread.
module tb_bus_memory_responder;
    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] dbg_tag = '0;
    logic [3:0] dbg_value;

    bus_memory_responder_if #(.TAG_W(2), .DATA_W(4)) bus ();

    bus_memory_responder #(
        .TAGS(4), .DATA_W(4), .LATENCY(2), .RM(1), .RH(2), .WB(3)
    ) dut (
        .clock(clock), .reset(reset), .bus(bus.slave),
        .dbg_tag(dbg_tag), .dbg_value(dbg_value)
    );

    always #10 clock = ~clock;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] exp_q[$];
    logic [7:0] exp_hold = '0;
    logic       prev_valid = 1'b0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%02h expected 0x%02h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: a rising resp_valid consumes one expectation; while held, data must not move
    always @(negedge clock) begin
        if (bus.resp_valid && !prev_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_resp", bus.resp_data, 8'hxx);
            end else begin
                exp_hold = exp_q.pop_front();
                check("resp_data", bus.resp_data, exp_hold);
            end
        end else if (bus.resp_valid) begin
            check("resp_data_stable", bus.resp_data, exp_hold);
        end
        prev_valid = bus.resp_valid;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic check_mem(input logic [1:0] tag, input logic [3:0] exp, input string name);
        dbg_tag = tag;
        #1;
        check(name, {4'h0, dbg_value}, {4'h0, exp});
    endtask

    task automatic check_all_zero(input string name);
        for (int t = 0; t < 4; t++) check_mem(2'(t), 4'h0, name);
    endtask

    // Holds the request until accepted; returns 1 time unit after the accept edge
    task automatic send(input logic [7:0] req);
        bit ok = 0;
        bus.bus_req       = req;
        bus.bus_req_valid = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clock);
            if (bus.bus_req_ready) begin
                ok = 1;
                break;
            end
        end
        if (!ok) check("accept_timeout", 8'h0, 8'h1);
        @(posedge clock);
        #1;
        bus.bus_req_valid = 1'b0;
    endtask

    task automatic wait_resp;
        bit ok = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (bus.resp_valid) begin
                ok = 1;
                break;
            end
        end
        if (!ok) check("resp_timeout", 8'h0, 8'h1);
    endtask

    task automatic do_read(input logic [7:0] req, input logic [7:0] exp);
        exp_q.push_back(exp);
        send(req);
        wait_resp();
        bus.resp_ready = 1'b1;
        tick();
        bus.resp_ready = 1'b0;
        check("ready_after_hs", {7'h0, bus.bus_req_ready}, 8'h1);
        check("valid_after_hs", {7'h0, bus.resp_valid}, 8'h0);
    endtask

    initial begin
        bus.bus_req       = '0;
        bus.bus_req_valid = 1'b0;
        bus.snoop_hit     = 1'b0;
        bus.snoop_value   = '0;
        bus.resp_ready    = 1'b0;
        tick(); tick();
        reset = 1'b0;

        check("rst_resp_valid", {7'h0, bus.resp_valid}, 8'h0);
        check("rst_resp_data", bus.resp_data, 8'h00);
        check("rst_ready", {7'h0, bus.bus_req_ready}, 8'h1);
        check_all_zero("rst_mem");

        // RM tag 2: response exactly LATENCY edges after accept
        exp_q.push_back(8'h60);
        send(8'h60);
        check("rm_busy", {7'h0, bus.bus_req_ready}, 8'h0);
        check("rm_lat_e0", {7'h0, bus.resp_valid}, 8'h0);
        tick();
        check("rm_lat_e1", {7'h0, bus.resp_valid}, 8'h0);
        tick();
        check("rm_lat_e2", {7'h0, bus.resp_valid}, 8'h1);
        check("rm_busy_respond", {7'h0, bus.bus_req_ready}, 8'h0);
        @(negedge clock);
        bus.resp_ready = 1'b1;
        tick();
        bus.resp_ready = 1'b0;
        check("rm_hs_ready", {7'h0, bus.bus_req_ready}, 8'h1);

        // WB tag1=A, visible the cycle after the WRITE edge, then read back
        send(8'hDA);
        check_mem(2'd1, 4'h0, "wb_before_commit");
        tick();
        check_mem(2'd1, 4'hA, "wb_commit");
        do_read(8'h50, 8'h5A);

        // RH and msg 0 are consumed without effect
        send(8'h9F);
        check("rh_ignored", {7'h0, bus.bus_req_ready}, 8'h1);
        send(8'h2F);
        check("msg0_ignored", {7'h0, bus.bus_req_ready}, 8'h1);
        check_mem(2'd1, 4'hA, "rh_no_write");

        // Snoop on first READ_WAIT cycle
        send(8'h50);
        bus.snoop_hit = 1'b1; bus.snoop_value = 4'h7;
        tick();
        bus.snoop_hit = 1'b0;
        check("snoop1_idle", {7'h0, bus.bus_req_ready}, 8'h1);
        check_mem(2'd1, 4'h7, "snoop1_mem");
        tick(); tick();
        check("snoop1_no_resp", {7'h0, bus.resp_valid}, 8'h0);

        // Snoop on the counter==0 cycle beats the response
        send(8'h70);
        tick();
        bus.snoop_hit = 1'b1; bus.snoop_value = 4'hC;
        tick();
        bus.snoop_hit = 1'b0;
        check("snoop0_idle", {7'h0, bus.bus_req_ready}, 8'h1);
        check("snoop0_no_resp", {7'h0, bus.resp_valid}, 8'h0);
        check_mem(2'd3, 4'hC, "snoop0_mem");

        // Snoop outside READ_WAIT is ignored
        bus.snoop_hit = 1'b1; bus.snoop_value = 4'h5;
        tick(); tick();
        bus.snoop_hit = 1'b0;
        check_mem(2'd3, 4'hC, "snoop_idle_ignored");

        // Stalled response with a pending WB held on the bus
        send(8'hC3);
        tick();
        exp_q.push_back(8'h43);
        send(8'h40);
        wait_resp();
        bus.bus_req = 8'hE9; bus.bus_req_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stall_ready", {7'h0, bus.bus_req_ready}, 8'h0);
            check("stall_valid", {7'h0, bus.resp_valid}, 8'h1);
        end
        check_mem(2'd2, 4'h0, "stall_no_accept");
        @(negedge clock);
        bus.resp_ready = 1'b1;
        tick();
        bus.resp_ready = 1'b0;
        check("stall_hs_ready", {7'h0, bus.bus_req_ready}, 8'h1);
        check("stall_hs_valid", {7'h0, bus.resp_valid}, 8'h0);
        tick();
        bus.bus_req_valid = 1'b0;
        check("held_wb_accepted", {7'h0, bus.bus_req_ready}, 8'h0);
        tick();
        check_mem(2'd2, 4'h9, "held_wb_mem");

        // Reset during READ_WAIT
        send(8'h60);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rst_rw_valid", {7'h0, bus.resp_valid}, 8'h0);
        check("rst_rw_ready", {7'h0, bus.bus_req_ready}, 8'h1);
        check_all_zero("rst_rw_mem");
        tick(); tick(); tick();
        check("rst_rw_no_resp", {7'h0, bus.resp_valid}, 8'h0);

        // Reset during RESPOND
        send(8'hD5);
        tick();
        exp_q.push_back(8'h55);
        send(8'h50);
        wait_resp();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rst_rsp_valid", {7'h0, bus.resp_valid}, 8'h0);
        check("rst_rsp_data", bus.resp_data, 8'h00);
        check("rst_rsp_ready", {7'h0, bus.bus_req_ready}, 8'h1);
        check_all_zero("rst_rsp_mem");

        tick(); tick();
        check("exp_queue_empty", 8'(exp_q.size()), 8'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
